// File: rtl/axis_reset_drain_responder.sv
// Inline AXI4-Stream reset-drain responder: finishes the in-flight packet, holds a local reset, then acknowledges.
// Optional drain timeout is compiled in with `define RST_DRAIN_TIMEOUT_EN.
module axis_reset_drain_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  rst_req,
  output logic                  rst_ack,
  output logic                  local_aresetn,
  output logic                  drain_timeout,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HOLD,
    ST_ACK,
    ST_RELEASE
  } state_t;

  localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axis_reset_drain_responder: HOLD_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  state_t            state;
  state_t            state_next;
  logic              in_pkt;
  logic              in_pkt_next;
  logic              pass;
  logic              beat_accept;
  logic              hold_done;
  logic              timeout_hit;
  logic [HOLD_W-1:0] hold_cnt;

  // Datapath is a wire; only the handshake is gated.
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid & pass;
  assign s_axis_tready = m_axis_tready & pass;

  assign beat_accept = s_axis_tvalid & m_axis_tready & pass;
  assign in_pkt_next = beat_accept ? ~s_axis_tlast : in_pkt;
  assign hold_done   = (hold_cnt == HOLD_LAST);

  // State register and the state-tracking local reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_RUN;
      in_pkt        <= 1'b0;
      hold_cnt      <= '0;
      local_aresetn <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state         <= state_next;
      in_pkt        <= (state_next == ST_HOLD) ? 1'b0 : in_pkt_next;
      hold_cnt      <= (state == ST_HOLD && !hold_done) ? hold_cnt + 1'b1 : '0;
      local_aresetn <= !(state_next == ST_HOLD || state_next == ST_ACK);
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      ST_RUN:     if (rst_req) state_next = ST_DRAIN;
      ST_DRAIN:   if (!in_pkt_next || timeout_hit) state_next = ST_HOLD;
      ST_HOLD:    if (hold_done) state_next = ST_ACK;
      ST_ACK:     if (!rst_req) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_RUN;
      default:    state_next = ST_RUN;
    endcase
  end

  // Output decode; aresetn low forces the link closed even before the first edge.
  always_comb begin
    pass    = aresetn & ((state == ST_RUN) | ((state == ST_DRAIN) & in_pkt));
    rst_ack = (state == ST_ACK);
  end

`ifdef RST_DRAIN_TIMEOUT_EN
  localparam int                 DRAIN_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(TIMEOUT_CYCLES - 1);

  logic [DRAIN_W-1:0] drain_cnt;
  logic               drain_timeout_q;

  // Only a drain that would otherwise continue counts as a forced termination.
  assign timeout_hit   = (state == ST_DRAIN) && in_pkt_next && (drain_cnt == DRAIN_LAST);
  assign drain_timeout = drain_timeout_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drain_cnt       <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
      if (timeout_hit) drain_timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign drain_timeout = 1'b0;
`endif

endmodule

// File: doc/axis_reset_drain_responder.md
Name: axis_reset_drain_responder

Overview:
- Responder end of the per-clock-domain reset-request path.
- Sits inline on one AXI4-Stream link inside a clock domain, between the upstream master and the downstream logic.
- On a reset request from the clock/reset map it finishes any in-flight packet and blocks new ones. It then drives a local active-low reset for a minimum hold time and acknowledges.
- It releases the local reset only after the request is withdrawn.

Parameters:
DATA_WIDTH, 32, tdata width in bits
HOLD_CYCLES, 16, minimum cycles local_aresetn is held low (>=1)
TIMEOUT_CYCLES, 1024, drain timeout in cycles; used only with RST_DRAIN_TIMEOUT_EN (>=2)

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
rst_req  input  1  reset request level, synchronous to aclk
rst_ack  output  1  reset acknowledge
local_aresetn  output  1  active-low reset to downstream logic
drain_timeout  output  1  sticky flag: drain was force-terminated
s_axis_tdata  input  DATA_WIDTH  upstream data
s_axis_tvalid  input  1  upstream valid
s_axis_tready  output  1  upstream ready
s_axis_tlast  input  1  upstream end of packet
m_axis_tdata  output  DATA_WIDTH  downstream data
m_axis_tvalid  output  1  downstream valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  downstream end of packet

Behaviour:
- Interface: one clock aclk; aresetn is asynchronous, active-low.
- Reset (aresetn=0) sets: state=RUN, in_pkt=0, counters=0, rst_ack=0, local_aresetn=0, drain_timeout=0. pass is forced 0.
- local_aresetn returns to 1 on the first aclk edge after aresetn deasserts.
- Datapath is combinational pass-through gated by pass:
  - m_axis_tvalid = s_axis_tvalid & pass
  - s_axis_tready = m_axis_tready & pass
  - tdata and tlast are wired straight through.
- pass = (state==RUN) | (state==DRAIN & in_pkt).
- in_pkt:
  - set on an accepted beat (tvalid & tready) with tlast=0;
  - cleared on an accepted beat with tlast=1;
  - cleared on entry to HOLD.
- States are registered. rst_ack = (state==ACK). local_aresetn = 0 in HOLD and ACK, 1 otherwise (registered, tracks state).
- RUN:
  - traffic passes;
  - rst_req=1 -> DRAIN next cycle. A beat accepted in that same cycle still completes and updates in_pkt.
- DRAIN:
  - passes only the remainder of the current packet;
  - when in_pkt_next==0 (includes a tlast handshake this cycle) -> HOLD next cycle;
  - if not in a packet on entry, stays exactly 1 cycle.
- HOLD:
  - pass=0;
  - counter runs 0..HOLD_CYCLES-1, then -> ACK;
  - rst_req changes are ignored.
- ACK:
  - pass=0, local_aresetn=0;
  - rst_req=0 -> RELEASE next cycle;
  - if rst_req is already low, ACK lasts exactly 1 cycle.
- RELEASE: local_aresetn=1, rst_ack=0, pass=0; one cycle, then RUN.
- A request is committed once DRAIN is entered. rst_req deasserting in DRAIN or HOLD does not abort the sequence.
- Idle latency, rst_req rise to rst_ack rise: HOLD_CYCLES+2 cycles.
- aresetn asserted in any state aborts immediately to reset values.

Optional Feature:
RST_DRAIN_TIMEOUT_EN
- Defined:
  - a DRAIN cycle counter starts at 0 on DRAIN entry;
  - if DRAIN has not exited when the counter reaches TIMEOUT_CYCLES-1 -> HOLD next cycle, in_pkt cleared, drain_timeout set to 1;
  - drain_timeout is sticky and cleared only by aresetn;
  - a truncated packet is not completed.
- Undefined: no counter logic; DRAIN waits indefinitely; drain_timeout tied 0.

Test Plan:
- Idle (HOLD_CYCLES=16): rst_req=1 at cycle 0, no traffic -> DRAIN at 1, HOLD cycles 2-17 with local_aresetn=0, rst_ack=1 at 18. Drop rst_req at 25 -> rst_ack=0 at 26 (RELEASE, local_aresetn=1), RUN at 27.
- Mid-packet: 8-beat packet, rst_req rises after beat 3 accepted -> beats 4-8 delivered intact. A second packet's tvalid is held with s_axis_tready=0. HOLD entered the cycle after beat 8 (tlast).
- With RST_DRAIN_TIMEOUT_EN, TIMEOUT_CYCLES=1024: in_pkt=1, m_axis_tready=0 -> HOLD after DRAIN cycle 1023, drain_timeout=1 and stays 1 after the sequence completes.
- Without the macro, same stimulus -> DRAIN persists for 5000 cycles, drain_timeout=0. Raise m_axis_tready and send tlast -> HOLD next cycle.
- One-cycle rst_req pulse -> full sequence; rst_ack high exactly 1 cycle; local_aresetn low HOLD_CYCLES+1 cycles.
- aresetn=0 during HOLD -> rst_ack=0, local_aresetn=0, s_axis_tready=0 immediately. After release -> RUN, local_aresetn=1 on the first edge, traffic passes.
